ram_dual_ctrl: RTL and testbench

Controller for the 64x8 dual-port RAM (`ram_dual`). It shares the RAM's single write port between two write requesters (A, B) and its single read port between two read requesters (A, B), using independent round-robin arbitration on each port. After reset it clears the whole array with an init sweep before accepting traffic. It sits between the requesters and `ram_dual` and drives that RAM's `write_clock` and `read_clock` from the same `clock`.

---
 rtl/ram_dual_ctrl_pkg.sv | 23 ++
 rtl/ram_dual_ctrl_rr_arb2.sv | 42 ++++
 rtl/ram_dual_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_dual_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dual_ctrl_pkg.sv
// ram_dual_ctrl_pkg
// Shared definitions for the dual-port RAM controller: default geometry,
// the controller state encoding and the requester-id encoding used by the
// round-robin arbiters and the read tag.
package ram_dual_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_INIT_VALUE = 0;

  // INIT sweeps the array to a known value, RUN serves requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Requester identity, also used as the round-robin priority value.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_dual_ctrl_rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter with a single priority bit.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   enable           - when low no grant is issued and priority is frozen
//   req_a, req_b     - requests
//   gnt_a, gnt_b     - combinational one-hot (or zero) grants
//   gnt_id           - id of the granted side, REQ_A when nothing granted
module rr_arb2
  import ram_dual_ctrl_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    enable,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_a,
  output logic    gnt_b,
  output req_id_t gnt_id
);

  req_id_t prio_q;

  // A lone requester always wins; on contention the priority holder wins.
  always_comb begin
    gnt_a  = enable && req_a && (!req_b || (prio_q == REQ_A));
    gnt_b  = enable && req_b && (!req_a || (prio_q == REQ_B));
    gnt_id = gnt_b ? REQ_B : REQ_A;
  end

  // Priority passes to the side that lost (or was not served) after a grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= REQ_A;
    end else if (gnt_a) begin
      prio_q <= REQ_B;
    end else if (gnt_b) begin
      prio_q <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_dual_ctrl.sv
// ram_dual_ctrl
// Controller for a simple dual-port RAM (one write port, one registered
// read port). After reset it writes INIT_VALUE to every address, then shares
// the write port between requesters A/B and the read port between A/B with
// independent round-robin arbiters.
// Ports:
//   clock, reset                 - single clock, synchronous active-high reset
//   {a,b}_wr_req/addr/data       - write requests, {a,b}_wr_gnt accept them
//   {a,b}_rd_req/addr            - read requests, {a,b}_rd_gnt accept them
//   {a,b}_rd_valid/data          - read return one cycle after the grant
//   ram_we/write_addr/data       - RAM write port
//   ram_read_addr, ram_q         - RAM read port (q registered in the RAM)
//   init_busy                    - init sweep in progress
module ram_dual_ctrl
  import ram_dual_ctrl_pkg::*;
#(
  parameter int                      DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                      ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE = DATA_WIDTH'(DEFAULT_INIT_VALUE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_wr_req,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_wr_gnt,
  input  logic                  b_wr_req,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_wr_gnt,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  a_rd_gnt,
  output logic                  a_rd_valid,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  b_rd_gnt,
  output logic                  b_rd_valid,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_busy
);

  ctrl_state_t           state;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic [ADDR_WIDTH:0]   init_cnt_next;
  logic                  arb_enable;
  req_id_t               wr_id;
  req_id_t               rd_id;
  logic                  rd_any;
  logic [ADDR_WIDTH-1:0] read_addr_mux;
  logic [ADDR_WIDTH-1:0] last_read_addr;
  logic                  tag_valid;
  req_id_t               tag_owner;

  // Reset is synchronous, so while it is held the arbiters must be muted
  // combinationally even if the state register still says RUN.
  assign arb_enable    = (state == RUN) && !reset;
  assign init_cnt_next = init_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign init_busy     = (state == INIT) || reset;

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_enable),
    .req_a  (a_wr_req),
    .req_b  (b_wr_req),
    .gnt_a  (a_wr_gnt),
    .gnt_b  (b_wr_gnt),
    .gnt_id (wr_id)
  );

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_enable),
    .req_a  (a_rd_req),
    .req_b  (b_rd_req),
    .gnt_a  (a_rd_gnt),
    .gnt_b  (b_rd_gnt),
    .gnt_id (rd_id)
  );

  // Init sweep: one address per cycle; the carry into the extra counter bit
  // marks that the last address has just been written, so RUN starts on the
  // following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt_next;
          if (init_cnt_next[ADDR_WIDTH]) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Write port: init sweep owns it in INIT, otherwise the granted requester.
  always_comb begin
    ram_we         = 1'b0;
    ram_write_addr = a_wr_addr;
    ram_data       = a_wr_data;
    if (state == INIT) begin
      ram_we         = !reset;
      ram_write_addr = init_cnt[ADDR_WIDTH-1:0];
      ram_data       = INIT_VALUE;
    end else begin
      ram_we = a_wr_gnt || b_wr_gnt;
      if (wr_id == REQ_B) begin
        ram_write_addr = b_wr_addr;
        ram_data       = b_wr_data;
      end
    end
  end

  // Read port address holds its last granted value when idle so the RAM
  // keeps reading a stable location.
  assign rd_any = a_rd_gnt || b_rd_gnt;

  always_comb begin
    read_addr_mux = (rd_id == REQ_B) ? b_rd_addr : a_rd_addr;
    if (state == INIT) begin
      ram_read_addr = '0;
    end else if (rd_any) begin
      ram_read_addr = read_addr_mux;
    end else begin
      ram_read_addr = last_read_addr;
    end
  end

  // Read tag follows the RAM's one-cycle q register so the returned word is
  // steered to the requester that was granted one cycle earlier.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_read_addr <= '0;
      tag_valid      <= 1'b0;
      tag_owner      <= REQ_A;
    end else begin
      if (rd_any) begin
        last_read_addr <= read_addr_mux;
      end
      tag_valid <= rd_any;
      tag_owner <= rd_id;
    end
  end

  // A read in flight when reset rises must not surface, so valid is also
  // masked during the reset cycle itself.
  assign a_rd_valid = tag_valid && (tag_owner == REQ_A) && !reset;
  assign b_rd_valid = tag_valid && (tag_owner == REQ_B) && !reset;
  assign a_rd_data  = ram_q;
  assign b_rd_data  = ram_q;

endmodule

// File: tb/tb_ram_dual_ctrl.sv
// tb_ram_dual_ctrl
// Directed bench for ram_dual_ctrl with a behavioural read-old RAM attached.
// Read expectations go into a scoreboard queue when a grant is expected; a
// separate monitor pops them when a read valid appears.
module tb_ram_dual_ctrl;

  typedef struct packed {
    logic       awr;
    logic [5:0] awa;
    logic [7:0] awd;
    logic       bwr;
    logic [5:0] bwa;
    logic [7:0] bwd;
    logic       ard;
    logic [5:0] ara;
    logic       brd;
    logic [5:0] bra;
    logic [3:0] gnt;
    logic [7:0] rdata;
  } vec_t;

  typedef struct packed {
    int         due;
    logic       owner;
    logic [7:0] data;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       a_wr_req, b_wr_req, a_rd_req, b_rd_req;
  logic [5:0] a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
  logic [7:0] a_wr_data, b_wr_data;
  logic       a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
  logic       a_rd_valid, b_rd_valid;
  logic [7:0] a_rd_data, b_rd_data;
  logic       ram_we;
  logic [5:0] ram_write_addr, ram_read_addr;
  logic [7:0] ram_data, ram_q;
  logic       init_busy;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  exp_t sb[$];

  logic [7:0] mem [64];
  logic       prefilled = 1'b0;

  ram_dual_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .a_wr_req       (a_wr_req),
    .a_wr_addr      (a_wr_addr),
    .a_wr_data      (a_wr_data),
    .a_wr_gnt       (a_wr_gnt),
    .b_wr_req       (b_wr_req),
    .b_wr_addr      (b_wr_addr),
    .b_wr_data      (b_wr_data),
    .b_wr_gnt       (b_wr_gnt),
    .a_rd_req       (a_rd_req),
    .a_rd_addr      (a_rd_addr),
    .a_rd_gnt       (a_rd_gnt),
    .a_rd_valid     (a_rd_valid),
    .a_rd_data      (a_rd_data),
    .b_rd_req       (b_rd_req),
    .b_rd_addr      (b_rd_addr),
    .b_rd_gnt       (b_rd_gnt),
    .b_rd_valid     (b_rd_valid),
    .b_rd_data      (b_rd_data),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_data       (ram_data),
    .ram_read_addr  (ram_read_addr),
    .ram_q          (ram_q),
    .init_busy      (init_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Read-old RAM; prefilled with 0xEE so a missing init sweep is visible.
  always @(posedge clock) begin
    if (!prefilled) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hEE;
      prefilled <= 1'b1;
    end else if (ram_we) begin
      mem[ram_write_addr] <= ram_data;
    end
    ram_q <= mem[ram_read_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic awr, input logic [5:0] awa, input logic [7:0] awd,
                                 input logic bwr, input logic [5:0] bwa, input logic [7:0] bwd,
                                 input logic ard, input logic [5:0] ara,
                                 input logic brd, input logic [5:0] bra,
                                 input logic [3:0] gnt, input logic [7:0] rdata);
    vec_t t;
    t.awr = awr; t.awa = awa; t.awd = awd;
    t.bwr = bwr; t.bwa = bwa; t.bwd = bwd;
    t.ard = ard; t.ara = ara; t.brd = brd; t.bra = bra;
    t.gnt = gnt; t.rdata = rdata;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    a_wr_req = t.awr; a_wr_addr = t.awa; a_wr_data = t.awd;
    b_wr_req = t.bwr; b_wr_addr = t.bwa; b_wr_data = t.bwd;
    a_rd_req = t.ard; a_rd_addr = t.ara;
    b_rd_req = t.brd; b_rd_addr = t.bra;
  endtask

  // Drive one vector for one cycle; grants and port muxing are checked at
  // the falling edge and any expected read return is queued for the monitor.
  task automatic runVector(input string tag, input vec_t t);
    exp_t e;
    applyStimulus(t);
    @(negedge clock);
    checkOutput({tag, "_gnt"}, 32'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}), 32'(t.gnt));
    if (t.gnt[3] || t.gnt[2]) begin
      checkOutput({tag, "_wport"}, 32'({ram_we, ram_write_addr, ram_data}),
                  t.gnt[3] ? 32'({1'b1, t.awa, t.awd}) : 32'({1'b1, t.bwa, t.bwd}));
    end else begin
      checkOutput({tag, "_we_idle"}, 32'(ram_we), 32'(0));
    end
    if (t.gnt[1] || t.gnt[0]) begin
      checkOutput({tag, "_raddr"}, 32'(ram_read_addr), t.gnt[1] ? 32'(t.ara) : 32'(t.bra));
      e.due   = cycle + 1;
      e.owner = t.gnt[0];
      e.data  = t.rdata;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  // Init sweep check: each cycle writes INIT_VALUE to the next address with
  // all grants low and the read address parked at 0.
  task automatic initSweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput($sformatf("init_%0d", i),
                  32'({init_busy, ram_we, ram_write_addr, ram_data,
                       a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, ram_read_addr}),
                  32'({1'b1, 1'b1, 6'(i), 8'h00, 4'b0000, 6'd0}));
      @(posedge clock);
      #1;
    end
  endtask

  task automatic runEntry();
    applyStimulus('0);
    @(negedge clock);
    checkOutput("run_entry", 32'({init_busy, ram_we}), 32'(0));
    @(posedge clock);
    #1;
  endtask

  // Monitor: a valid must match the oldest expectation due this very cycle.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due <= cycle) begin
      e = sb.pop_front();
      checkOutput("rd_valid", 32'({a_rd_valid, b_rd_valid}), e.owner ? 32'(2'b01) : 32'(2'b10));
      checkOutput("rd_data", 32'(e.owner ? b_rd_data : a_rd_data), 32'(e.data));
    end else if (a_rd_valid || b_rd_valid) begin
      checkOutput("rd_valid_unexpected", 32'({a_rd_valid, b_rd_valid}), 32'(0));
    end
  end

  vec_t idle;

  initial begin
    idle = '0;
    reset = 1'b1;
    applyStimulus(mkVec(1, 6'd9, 8'h99, 0, 0, 0, 0, 0, 1, 6'd5, 4'b0000, 0));

    // Reset outputs with requests pending
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_outputs",
                32'({init_busy, ram_we, a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, a_rd_valid, b_rd_valid}),
                32'(8'b1000_0000));
    @(posedge clock);
    #1;
    reset = 1'b0;
    initSweep(64);
    runEntry();

    // Back-to-back reads of the whole array
    for (int i = 0; i < 64; i++) begin
      runVector("sweep", mkVec(0, 0, 0, 0, 0, 0, 1, 6'(i), 0, 0, 4'b0010, 8'h00));
    end
    runVector("idle", idle);

    // Single write by A, read back by B
    runVector("single_wr", mkVec(1, 6'd12, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0));
    runVector("single_rd", mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd12, 4'b0001, 8'h5A));
    runVector("idle", idle);

    // B write hands write priority back to A, then 4 cycles of contention
    runVector("b_wr", mkVec(0, 0, 0, 1, 6'd3, 8'h33, 0, 0, 0, 0, 4'b0100, 0));
    runVector("wcont0", mkVec(1, 6'd1, 8'hA1, 1, 6'd2, 8'hB2, 0, 0, 0, 0, 4'b1000, 0));
    runVector("wcont1", mkVec(1, 6'd1, 8'hA1, 1, 6'd2, 8'hB2, 0, 0, 0, 0, 4'b0100, 0));
    runVector("wcont2", mkVec(1, 6'd1, 8'hA1, 1, 6'd2, 8'hB2, 0, 0, 0, 0, 4'b1000, 0));
    runVector("wcont3", mkVec(1, 6'd1, 8'hA1, 1, 6'd2, 8'hB2, 0, 0, 0, 0, 4'b0100, 0));
    runVector("rd_a1", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd1, 0, 0, 4'b0010, 8'hA1));
    runVector("rd_b2", mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd2, 4'b0001, 8'hB2));

    // Read contention, alternating owners every cycle
    runVector("rcont0", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd1, 1, 6'd2, 4'b0010, 8'hA1));
    runVector("rcont1", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd1, 1, 6'd2, 4'b0001, 8'hB2));
    runVector("rcont2", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd1, 1, 6'd2, 4'b0010, 8'hA1));
    runVector("rcont3", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd1, 1, 6'd2, 4'b0001, 8'hB2));
    runVector("idle", idle);
    @(negedge clock);
    checkOutput("rd_addr_hold", 32'(ram_read_addr), 32'(2));
    @(posedge clock);
    #1;

    // Read-during-write on the same address returns the old word
    runVector("rdw_pre", mkVec(1, 6'd7, 8'h11, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0));
    runVector("rdw", mkVec(1, 6'd7, 8'h22, 0, 0, 0, 0, 0, 1, 6'd7, 4'b1001, 8'h11));
    runVector("rdw_post", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd7, 0, 0, 4'b0010, 8'h22));
    runVector("idle", idle);

    // Reset with a read in flight: its valid must never appear
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 6'd12, 0, 0, 4'b0000, 0));
    @(negedge clock);
    checkOutput("inflight_gnt", 32'(a_rd_gnt), 32'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(idle);
    @(negedge clock);
    checkOutput("inflight_cleared",
                32'({a_rd_valid, b_rd_valid, init_busy, ram_we, a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}),
                32'(8'b0010_0000));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset again in the middle of the sweep (address 30), then a full sweep
    applyStimulus(mkVec(1, 6'd9, 8'h99, 0, 0, 0, 0, 0, 1, 6'd5, 4'b0000, 0));
    initSweep(30);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_mid_init",
                32'({init_busy, ram_we, a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}),
                32'(6'b100000));
    @(posedge clock);
    #1;
    reset = 1'b0;
    initSweep(64);
    runEntry();

    // Priority back at A after reset; init cleared the earlier 0x5A
    runVector("post_wcont", mkVec(1, 6'd5, 8'h55, 1, 6'd6, 8'h66, 0, 0, 0, 0, 4'b1000, 0));
    runVector("post_rd12", mkVec(0, 0, 0, 0, 0, 0, 1, 6'd12, 0, 0, 4'b0010, 8'h00));
    runVector("post_rd5", mkVec(0, 0, 0, 1, 6'd6, 8'h66, 1, 6'd5, 0, 0, 4'b0110, 8'h55));
    runVector("post_rd6", mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'd6, 4'b0001, 8'h66));
    runVector("idle", idle);
    runVector("idle", idle);

    checkOutput("sb_drain", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
